// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - initiator-side sequencer for the 16x4 asynchronous RAM
//
// Converts a valid/ready request stream into setup/strobe/hold RAM pin
// activity, returns read data over a valid/ready response channel, and runs
// a self-timed clear sweep that writes CLEAR_VALUE to all 16 cells.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_write/req_addr/req_wdata    request payload (1 = write)
//   rsp_valid/rsp_ready/rsp_rdata   read response handshake and data
//   clear_start/clear_done          start pulse / completion pulse of clear sweep
//   busy                            high whenever not IDLE
//   ram_cs/ram_write_en             RAM select (active high) / write strobe (active low)
//   ram_addr/ram_wdata/ram_rdata    RAM address, write data, read data
module ram_access_ctrl #(
  parameter int         WR_PULSE    = 1,
  parameter int         RD_WAIT     = 1,
  parameter logic [3:0] CLEAR_VALUE = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [3:0] req_addr,
  input  logic [3:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_rdata,
  input  logic       clear_start,
  output logic       clear_done,
  output logic       busy,
  output logic       ram_cs,
  output logic       ram_write_en,
  output logic [3:0] ram_addr,
  output logic [3:0] ram_wdata,
  input  logic [3:0] ram_rdata
);

  localparam int MAXP = (WR_PULSE > RD_WAIT) ? WR_PULSE : RD_WAIT;
  localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RSP
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_clear, w_clear_nxt;
  logic [3:0]      r_sweep, w_sweep_nxt;
  logic            r_write, w_write_nxt;
  logic            r_cs, w_cs_nxt;
  logic            r_write_en, w_write_en_nxt;
  logic [3:0]      r_addr, w_addr_nxt;
  logic [3:0]      r_wdata, w_wdata_nxt;
  logic            r_rsp_valid, w_rsp_valid_nxt;
  logic [3:0]      r_rdata, w_rdata_nxt;
  logic            r_clear_done, w_clear_done_nxt;
  logic [CW-1:0]   w_last;
  logic            w_idle_open;

  // Acceptance window without rst_n so the reset net never feeds a flop D input;
  // the reset gating is applied only on the req_ready output itself.
  assign w_idle_open = (r_state == ST_IDLE) && !clear_start;
  assign w_last      = r_write ? CW'(WR_PULSE - 1) : CW'(RD_WAIT - 1);

  assign req_ready    = w_idle_open && rst_n;
  assign busy         = (r_state != ST_IDLE);
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rdata;
  assign clear_done   = r_clear_done;
  assign ram_cs       = r_cs;
  assign ram_write_en = r_write_en;
  assign ram_addr     = r_addr;
  assign ram_wdata    = r_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_clear      <= 1'b0;
      r_sweep      <= 4'h0;
      r_write      <= 1'b0;
      r_cs         <= 1'b0;
      r_write_en   <= 1'b1;
      r_addr       <= 4'h0;
      r_wdata      <= 4'h0;
      r_rsp_valid  <= 1'b0;
      r_rdata      <= 4'h0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_clear      <= w_clear_nxt;
      r_sweep      <= w_sweep_nxt;
      r_write      <= w_write_nxt;
      r_cs         <= w_cs_nxt;
      r_write_en   <= w_write_en_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rdata      <= w_rdata_nxt;
      r_clear_done <= w_clear_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_clear_nxt      = r_clear;
    w_sweep_nxt      = r_sweep;
    w_write_nxt      = r_write;
    w_cs_nxt         = r_cs;
    w_write_en_nxt   = r_write_en;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rdata_nxt      = r_rdata;
    w_clear_done_nxt = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // clear_start wins over a simultaneous request
        if (clear_start) begin
          w_state_nxt = ST_SETUP;
          w_clear_nxt = 1'b1;
          w_sweep_nxt = 4'h0;
          w_write_nxt = 1'b1;
          w_addr_nxt  = 4'h0;
          w_wdata_nxt = CLEAR_VALUE;
        end else if (req_valid && w_idle_open) begin
          w_state_nxt = ST_SETUP;
          w_write_nxt = req_write;
          w_addr_nxt  = req_addr;
          w_wdata_nxt = req_wdata;
        end
      end
      ST_SETUP: begin
        // address/data have been stable for a full cycle with cs low
        w_state_nxt    = ST_STROBE;
        w_cs_nxt       = 1'b1;
        w_write_en_nxt = !r_write;
        w_cnt_nxt      = '0;
      end
      ST_STROBE: begin
        if (r_cnt == w_last) begin
          w_state_nxt    = ST_HOLD;
          w_cs_nxt       = 1'b0;
          w_write_en_nxt = 1'b1;
          if (!r_write) begin
            w_rdata_nxt = ram_rdata;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_HOLD: begin
        if (r_clear) begin
          if (r_sweep == 4'hF) begin
            w_state_nxt      = ST_IDLE;
            w_clear_nxt      = 1'b0;
            w_sweep_nxt      = 4'h0;
            w_clear_done_nxt = 1'b1;
          end else begin
            // next cell's address is presented while cs is low
            w_state_nxt = ST_SETUP;
            w_sweep_nxt = r_sweep + 4'd1;
            w_addr_nxt  = r_sweep + 4'd1;
          end
        end else if (r_write) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt     = ST_RSP;
          w_rsp_valid_nxt = 1'b1;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - self-checking bench for ram_access_ctrl
module tb_ram_access_ctrl;

  localparam int         WRP  = 1;
  localparam int         RDW  = 1;
  localparam int         WRP2 = 3;
  localparam int         RDW2 = 2;
  localparam logic [3:0] CLRV = 4'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       we_n;
    logic [3:0] addr;
    logic [3:0] wdata;
    int         len;
  } strobe_t;

  // default-parameter instance
  logic       rv0 = 1'b0, rw0 = 1'b0, rr0 = 1'b0, cst0 = 1'b0;
  logic [3:0] ra0 = 4'h0, rwd0 = 4'h0;
  logic       rdy0, rspv0, cdone0, busy0, cs0, we0;
  logic [3:0] rdata0, addr0, wd0, ramrd0;
  logic [3:0] ram0 [16];
  logic [3:0] exp0 [16];
  strobe_t    log0 [$];
  strobe_t    cur0;
  logic       pcs0 = 1'b0;
  int         viol0 = 0;

  // long-pulse instance
  logic       rv2 = 1'b0, rw2 = 1'b0, rr2 = 1'b0, cst2 = 1'b0;
  logic [3:0] ra2 = 4'h0, rwd2 = 4'h0;
  logic       rdy2, rspv2, cdone2, busy2, cs2, we2;
  logic [3:0] rdata2, addr2, wd2, ramrd2;
  logic [3:0] ram2 [16];
  strobe_t    log2 [$];
  strobe_t    cur2;
  logic       pcs2 = 1'b0;
  int         viol2 = 0;

  assign ramrd0 = ram0[addr0];
  assign ramrd2 = ram2[addr2];

  ram_access_ctrl #(.WR_PULSE(WRP), .RD_WAIT(RDW), .CLEAR_VALUE(CLRV)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv0), .req_ready(rdy0), .req_write(rw0), .req_addr(ra0), .req_wdata(rwd0),
    .rsp_valid(rspv0), .rsp_ready(rr0), .rsp_rdata(rdata0),
    .clear_start(cst0), .clear_done(cdone0), .busy(busy0),
    .ram_cs(cs0), .ram_write_en(we0), .ram_addr(addr0), .ram_wdata(wd0), .ram_rdata(ramrd0)
  );

  ram_access_ctrl #(.WR_PULSE(WRP2), .RD_WAIT(RDW2), .CLEAR_VALUE(CLRV)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv2), .req_ready(rdy2), .req_write(rw2), .req_addr(ra2), .req_wdata(rwd2),
    .rsp_valid(rspv2), .rsp_ready(rr2), .rsp_rdata(rdata2),
    .clear_start(cst2), .clear_done(cdone2), .busy(busy2),
    .ram_cs(cs2), .ram_write_en(we2), .ram_addr(addr2), .ram_wdata(wd2), .ram_rdata(ramrd2)
  );

  // RAM model plus strobe recorder: logs each cs pulse and flags any pin change while cs is high
  always @(negedge clk) begin
    if (cs0) begin
      if (pcs0 && (addr0 !== cur0.addr || wd0 !== cur0.wdata || we0 !== cur0.we_n)) viol0++;
      if (!pcs0) begin
        cur0.we_n = we0; cur0.addr = addr0; cur0.wdata = wd0; cur0.len = 0;
      end
      cur0.len++;
      if (!we0) ram0[addr0] = wd0;
    end else if (pcs0) begin
      log0.push_back(cur0);
    end
    pcs0 = cs0;
  end

  always @(negedge clk) begin
    if (cs2) begin
      if (pcs2 && (addr2 !== cur2.addr || wd2 !== cur2.wdata || we2 !== cur2.we_n)) viol2++;
      if (!pcs2) begin
        cur2.we_n = we2; cur2.addr = addr2; cur2.wdata = wd2; cur2.len = 0;
      end
      cur2.len++;
      if (!we2) ram2[addr2] = wd2;
    end else if (pcs2) begin
      log2.push_back(cur2);
    end
    pcs2 = cs2;
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic issue0(input logic w, input logic [3:0] a, input logic [3:0] d, output bit ok);
    int n;
    n = 0;
    rv0 = 1'b1; rw0 = w; ra0 = a; rwd0 = d;
    @(negedge clk);
    while (!rdy0 && n < 100) begin @(negedge clk); n++; end
    ok = rdy0;
    @(posedge clk); #1;
    rv0 = 1'b0;
  endtask

  task automatic wait_idle0(output int k);
    k = 0;
    do begin @(negedge clk); k++; end while (!rdy0 && k < 50);
    @(posedge clk); #1;
  endtask

  task automatic write0(input logic [3:0] a, input logic [3:0] d, output int k);
    bit ok;
    issue0(1'b1, a, d, ok);
    wait_idle0(k);
    if (!ok) k = -1;
  endtask

  task automatic read0(input logic [3:0] a, input int dly, output logic [3:0] data, output int lat);
    bit ok;
    rr0 = 1'b0;
    issue0(1'b0, a, 4'h0, ok);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rspv0 && lat < 50);
    if (!ok) lat = -1;
    data = rdata0;
    repeat (dly) @(negedge clk);
    rr0 = 1'b1;
    @(posedge clk); #1;
    rr0 = 1'b0;
  endtask

  task automatic issue2(input logic w, input logic [3:0] a, input logic [3:0] d, output bit ok);
    int n;
    n = 0;
    rv2 = 1'b1; rw2 = w; ra2 = a; rwd2 = d;
    @(negedge clk);
    while (!rdy2 && n < 100) begin @(negedge clk); n++; end
    ok = rdy2;
    @(posedge clk); #1;
    rv2 = 1'b0;
  endtask

  task automatic write2(input logic [3:0] a, input logic [3:0] d, output int k);
    bit ok;
    issue2(1'b1, a, d, ok);
    k = 0;
    do begin @(negedge clk); k++; end while (!rdy2 && k < 50);
    @(posedge clk); #1;
    if (!ok) k = -1;
  endtask

  task automatic read2(input logic [3:0] a, output logic [3:0] data, output int lat);
    bit ok;
    rr2 = 1'b0;
    issue2(1'b0, a, 4'h0, ok);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rspv2 && lat < 50);
    if (!ok) lat = -1;
    data = rdata2;
    rr2 = 1'b1;
    @(posedge clk); #1;
    rr2 = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ram0[i] = 4'($urandom);
      ram2[i] = 4'($urandom);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cs0, we0, addr0, wd0} !== 10'b01_0000_0000) begin
      errors++; $display("FAIL reset_ram_pins got %b want %b", {cs0, we0, addr0, wd0}, 10'b01_0000_0000);
    end
    checks++;
    if ({rspv0, rdata0, cdone0, busy0, rdy0} !== 8'b0) begin
      errors++; $display("FAIL reset_status got %b want %b", {rspv0, rdata0, cdone0, busy0, rdy0}, 8'b0);
    end
    checks++;
    if ({cs2, we2, busy2, rdy2} !== 4'b0100) begin
      errors++; $display("FAIL reset_dut2 got %b want %b", {cs2, we2, busy2, rdy2}, 4'b0100);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_write_timing();
    bit ok;
    logic [10:0] got, want;
    logic strobe;
    log0.delete();
    issue0(1'b1, 4'h5, 4'hA, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL write_accept got %0d want 1", ok); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      strobe = (k >= 2) && (k < 2 + WRP);
      want = {strobe, !strobe, 4'h5, 4'hA, (k >= 3 + WRP)};
      got  = {cs0, we0, addr0, wd0, rdy0};
      checks++;
      if (got !== want) begin errors++; $display("FAIL write_cycle%0d got %b want %b", k, got, want); end
      @(posedge clk); #1;
    end
    exp0[5] = 4'hA;
    checks++;
    if (log0.size() != 1 || log0[0].len != WRP || log0[0].we_n !== 1'b0 || log0[0].addr !== 4'h5 || log0[0].wdata !== 4'hA) begin
      errors++; $display("FAIL write_strobe_log got %0d strobes want 1 of len %0d", log0.size(), WRP);
    end
  endtask

  task automatic test_write_read();
    bit ok;
    int k, wefall;
    write0(4'h2, 4'h3, k);
    checks++;
    if (k != 3 + WRP) begin errors++; $display("FAIL wr_ready_return got %0d want %0d", k, 3 + WRP); end
    exp0[2] = 4'h3;
    rr0 = 1'b1;
    issue0(1'b0, 4'h2, 4'h0, ok);
    wefall = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (!we0) wefall++;
      checks++;
      if (rspv0 !== (c == 3 + RDW)) begin errors++; $display("FAIL rd_valid_cycle%0d got %b want %b", c, rspv0, (c == 3 + RDW)); end
      if (c == 3 + RDW) begin
        checks++;
        if (rdata0 !== exp0[2]) begin errors++; $display("FAIL rd_data got %h want %h", rdata0, exp0[2]); end
      end
      @(posedge clk); #1;
    end
    rr0 = 1'b0;
    checks++;
    if (wefall != 0) begin errors++; $display("FAIL rd_we_low got %0d want 0", wefall); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int k, lat;
    logic [3:0] a, d;
    a = 4'($urandom); d = 4'($urandom);
    write0(a, d, k);
    exp0[a] = d;
    rr0 = 1'b0;
    issue0(1'b0, a, 4'h0, ok);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rspv0 && lat < 50);
    checks++;
    if (lat != 3 + RDW || rdata0 !== d) begin errors++; $display("FAIL bp_first got lat %0d data %h want lat %0d data %h", lat, rdata0, 3 + RDW, d); end
    rv0 = 1'b1; rw0 = 1'b1; ra0 = a ^ 4'hF; rwd0 = ~d;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({rspv0, rdata0, rdy0, busy0} !== {1'b1, d, 1'b0, 1'b1}) begin
        errors++; $display("FAIL bp_hold%0d got %b want %b", i, {rspv0, rdata0, rdy0, busy0}, {1'b1, d, 1'b0, 1'b1});
      end
    end
    rr0 = 1'b1;
    @(posedge clk); #1;
    rr0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({rspv0, rdata0, rdy0} !== {1'b0, d, 1'b1}) begin
      errors++; $display("FAIL bp_after_hs got %b want %b", {rspv0, rdata0, rdy0}, {1'b0, d, 1'b1});
    end
    @(posedge clk); #1;
    rv0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy0, addr0, wd0} !== {1'b1, a ^ 4'hF, ~d}) begin
      errors++; $display("FAIL bp_next_accept got %b want %b", {busy0, addr0, wd0}, {1'b1, a ^ 4'hF, ~d});
    end
    wait_idle0(k);
    exp0[a ^ 4'hF] = ~d;
  endtask

  task automatic test_clear();
    int k, lat, busy_bad, done_k, done_n, sweep_bad;
    logic [3:0] data;
    for (int i = 0; i < 16; i++) begin
      write0(4'(i), 4'hF, k);
      exp0[i] = 4'hF;
    end
    log0.delete();
    cst0 = 1'b1; rv0 = 1'b1; rw0 = 1'b0; ra0 = 4'h3;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b0) begin errors++; $display("FAIL clr_ready got %b want 0", rdy0); end
    @(posedge clk); #1;
    cst0 = 1'b0; rv0 = 1'b0;
    busy_bad = 0; done_k = -1; done_n = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if ((c <= 48) !== busy0) busy_bad++;
      if (cdone0) begin
        done_n++;
        if (done_k < 0) done_k = c;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done_k != 49 || done_n != 1) begin errors++; $display("FAIL clr_done got cycle %0d count %0d want cycle 49 count 1", done_k, done_n); end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL clr_busy got %0d bad cycles want 0", busy_bad); end
    sweep_bad = (log0.size() != 16) ? 1 : 0;
    for (int i = 0; i < log0.size(); i++) begin
      if (log0[i].addr !== 4'(i) || log0[i].wdata !== CLRV || log0[i].we_n !== 1'b0 || log0[i].len != WRP) sweep_bad++;
    end
    checks++;
    if (sweep_bad != 0) begin errors++; $display("FAIL clr_sweep got %0d strobes %0d bad want 16 good", log0.size(), sweep_bad); end
    for (int i = 0; i < 16; i++) exp0[i] = CLRV;
    read0(4'h0, 0, data, lat);
    checks++;
    if (data !== exp0[0]) begin errors++; $display("FAIL clr_read0 got %h want %h", data, exp0[0]); end
    read0(4'hF, 1, data, lat);
    checks++;
    if (data !== exp0[15]) begin errors++; $display("FAIL clr_read15 got %h want %h", data, exp0[15]); end
  endtask

  task automatic test_random();
    int k, lat;
    logic [3:0] a, d, data;
    for (int n = 0; n < 30; n++) begin
      a = 4'($urandom); d = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        write0(a, d, k);
        exp0[a] = d;
        checks++;
        if (k != 3 + WRP) begin errors++; $display("FAIL rnd_write%0d got %0d want %0d", n, k, 3 + WRP); end
      end else begin
        read0(a, $urandom_range(0, 3), data, lat);
        checks++;
        if (data !== exp0[a] || lat != 3 + RDW) begin
          errors++; $display("FAIL rnd_read%0d got %h/%0d want %h/%0d", n, data, lat, exp0[a], 3 + RDW);
        end
      end
    end
  endtask

  task automatic test_long_pulse();
    int k, lat, last;
    logic [3:0] a, d, data;
    log2.delete();
    for (int n = 0; n < 4; n++) begin
      a = 4'($urandom); d = 4'($urandom);
      write2(a, d, k);
      last = log2.size() - 1;
      checks++;
      if (k != 3 + WRP2 || last < 0 || log2[last].len != WRP2 || log2[last].we_n !== 1'b0 || log2[last].addr !== a || log2[last].wdata !== d) begin
        errors++; $display("FAIL long_write%0d got ready %0d strobes %0d want ready %0d len %0d", n, k, log2.size(), 3 + WRP2, WRP2);
      end
      read2(a, data, lat);
      last = log2.size() - 1;
      checks++;
      if (data !== d || lat != 3 + RDW2 || last < 0 || log2[last].len != RDW2 || log2[last].we_n !== 1'b1) begin
        errors++; $display("FAIL long_read%0d got %h/%0d want %h/%0d", n, data, lat, d, 3 + RDW2);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n, bad;
    rr0 = 1'b0;
    issue0(1'b0, 4'h1, 4'h0, ok);
    @(posedge clk); #1;
    checks++;
    if ({cs0, we0} !== 2'b11) begin errors++; $display("FAIL rm_read_strobe got %b want 11", {cs0, we0}); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cs0, we0, busy0} !== 3'b010) begin errors++; $display("FAIL rm_read_abort got %b want 010", {cs0, we0, busy0}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1) begin errors++; $display("FAIL rm_read_ready got %b want 1", rdy0); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rspv0 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rm_no_rsp got %0d want 0", bad); end
    @(posedge clk); #1;
    cst0 = 1'b1;
    @(posedge clk); #1;
    cst0 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(cs0 && addr0 == 4'h7) && n < 60) begin @(negedge clk); n++; end
    checks++;
    if ({cs0, addr0} !== {1'b1, 4'h7}) begin errors++; $display("FAIL rm_sweep_reach got %b want %b", {cs0, addr0}, {1'b1, 4'h7}); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cs0, we0, busy0} !== 3'b010) begin errors++; $display("FAIL rm_clear_abort got %b want 010", {cs0, we0, busy0}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1) begin errors++; $display("FAIL rm_clear_ready got %b want 1", rdy0); end
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cdone0 || busy0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rm_no_done got %0d want 0", bad); end
  endtask

  task automatic test_stability();
    checks++;
    if (viol0 != 0) begin errors++; $display("FAIL pins_stable_dut got %0d want 0", viol0); end
    checks++;
    if (viol2 != 0) begin errors++; $display("FAIL pins_stable_dut2 got %0d want 0", viol2); end
  endtask

  initial begin
    test_reset();
    test_write_timing();
    test_write_read();
    test_backpressure();
    test_clear();
    test_random();
    test_long_pulse();
    test_stability();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
Initiator-side controller for the 16x4 asynchronous RAM, which has active-low write strobe, chip select and a latch-based cell array. It converts a clocked valid/ready request stream from the CPU datapath into correctly sequenced RAM pin activity: setup, strobe and hold, with address and data stable around every strobe. It returns read data over a valid/ready response channel. It also provides a self-timed clear sweep that writes a constant to all 16 cells at start-up.

Parameters:
WR_PULSE, 1, cycles ram_cs is held high with ram_write_en low during a write (>=1).
RD_WAIT, 1, cycles ram_cs is held high with ram_write_en high before read data is sampled (>=1).
CLEAR_VALUE, 4'h0, data written to every cell by the clear sweep.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request this cycle
req_write  in  1  1 = write, 0 = read
req_addr  in  4  target cell
req_wdata  in  4  write data
rsp_valid  out  1  read data available
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  4  read data, stable while rsp_valid
clear_start  in  1  pulse: begin clear sweep
clear_done  out  1  one-cycle pulse when sweep completes
busy  out  1  high in any state other than IDLE
ram_cs  out  1  RAM chip select, active high
ram_write_en  out  1  RAM write strobe, 0 = write, 1 = read/idle
ram_addr  out  4  RAM address
ram_wdata  out  4  RAM write data
ram_rdata  in  4  RAM read data (combinational from RAM)

Behaviour:
- All RAM-side outputs are registered and glitch-free.
- Reset (rst_n low, async): state=IDLE; ram_cs=0, ram_write_en=1, ram_addr=0, ram_wdata=0; rsp_valid=0, rsp_rdata=0; clear_done=0; busy=0. req_ready=0 while rst_n low.
- Reset mid-operation: the RAM strobe drops immediately, any pending response is discarded, and a clear sweep is aborted without clear_done.
- States: IDLE, SETUP, STROBE, HOLD, RSP, with a clear flag and a 4-bit sweep counter.
- req_ready = (state==IDLE) && !clear_start. Acceptance = req_valid && req_ready.
- Invariant: ram_addr and ram_wdata change only while ram_cs=0. ram_write_en changes only while ram_cs=0.
- Accept at edge T: latch addr, data and write into ram_addr/ram_wdata. SETUP is the cycle after T, with ram_cs=0 and ram_write_en=1.
- Write: STROBE lasts WR_PULSE cycles with ram_cs=1 and ram_write_en=0. HOLD follows for 1 cycle with ram_cs=0 and ram_write_en=1; address and data are held. Then IDLE. With defaults, req_ready returns 4 cycles after acceptance. No response is generated.
- Read: STROBE lasts RD_WAIT cycles with ram_cs=1 and ram_write_en=1. ram_rdata is sampled into rsp_rdata at the end of the last STROBE cycle. HOLD follows for 1 cycle, then RSP. In RSP, rsp_valid=1 and the state is held until rsp_ready; on the handshake edge the block enters IDLE and rsp_valid=0. With defaults, rsp_valid rises 4 cycles after acceptance.
- rsp_rdata holds its last value after the handshake.
- Clear: clear_start sampled in IDLE has priority over req_valid in the same cycle. The counter is set to 0, the flag is set and busy=1. The block runs the write sequence (SETUP/STROBE/HOLD) with ram_wdata=CLEAR_VALUE for addr 0..15 in order. After HOLD of addr 15 the counter wraps to 0, the flag clears, clear_done pulses for 1 cycle and the state returns to IDLE. With defaults the sweep takes 48 cycles.
- clear_start outside IDLE is ignored (not queued).
- req_* inputs are ignored unless accepted. Back-to-back requests are allowed: a new acceptance can occur in the first IDLE cycle.

Test Plan:
1. Reset release, then write addr=4'h5 data=4'hA -> exactly 1 cycle with ram_cs=1/ram_write_en=0/addr=5/wdata=A; cs=0 on the setup and hold cycles; req_ready high again 4 cycles after acceptance.
2. Write 4'h3->addr 2, then read addr 2 with rsp_ready=1 -> rsp_valid pulses 1 cycle with rsp_rdata=4'h3; ram_write_en never goes low during the read.
3. Read with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; acceptance of a new request only after the handshake.
4. clear_start and req_valid asserted in the same cycle after writing 4'hF to all cells -> request not accepted; 16 write strobes at addr 0..15 with wdata=0; clear_done after 48 cycles; subsequent reads of addr 0 and addr 15 return 4'h0.
5. WR_PULSE=3, RD_WAIT=2 -> the write strobe spans 3 cycles and the read strobe spans 2 cycles; the monitor confirms addr/wdata never change while ram_cs=1.
6. rst_n pulled low during STROBE of a read and during clear sweep addr 7 -> ram_cs=0 and ram_write_en=1 immediately; no rsp_valid or clear_done after release; req_ready=1 on the first cycle after release.
